wishbone_rr_interconnect: RTL and testbench

Shared-bus Wishbone interconnect that connects N_MASTER masters to N_SLAVE slaves. It generalises data and address width and replaces fixed priority with registered round-robin arbitration. Bus lock holds ownership across cycles, and a decode miss answers with a synthesised error. It sits between the core, DMA and debug masters and the memory and peripheral slaves.

---
 rtl/wishbone_rr_interconnect_if.sv | 66 ++++++
 rtl/wishbone_rr_interconnect.sv | 190 +++++++++++++++++++
 tb/tb_wishbone_rr_interconnect.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_rr_interconnect_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wishbone_rr_interconnect_if : master- and slave-side bus bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface wishbone_rr_interconnect_if #(
  parameter int N_MASTER = 2,
  parameter int N_SLAVE  = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int TAGSIZE  = 2
);
  logic [N_MASTER*DATA_W-1:0]     m_dat_i;
  logic [N_MASTER*ADDR_W-1:0]     m_adr_i;
  logic [N_MASTER*(DATA_W/8)-1:0] m_sel_i;
  logic [N_MASTER*TAGSIZE-1:0]    m_tgd_i;
  logic [N_MASTER*TAGSIZE-1:0]    m_tga_i;
  logic [N_MASTER*TAGSIZE-1:0]    m_tgc_i;
  logic [N_MASTER-1:0]            m_cyc_i;
  logic [N_MASTER-1:0]            m_stb_i;
  logic [N_MASTER-1:0]            m_we_i;
  logic [N_MASTER-1:0]            m_lock_i;
  logic [DATA_W-1:0]              m_dat_o;
  logic [TAGSIZE-1:0]             m_tgd_o;
  logic [N_MASTER-1:0]            m_ack_o;
  logic [N_MASTER-1:0]            m_err_o;
  logic [N_MASTER-1:0]            m_rty_o;
  logic [N_MASTER-1:0]            m_gnt_o;

  logic [DATA_W-1:0]              s_dat_o;
  logic [ADDR_W-1:0]              s_adr_o;
  logic [DATA_W/8-1:0]            s_sel_o;
  logic [TAGSIZE-1:0]             s_tgd_o;
  logic [TAGSIZE-1:0]             s_tga_o;
  logic [TAGSIZE-1:0]             s_tgc_o;
  logic                           s_we_o;
  logic [N_SLAVE-1:0]             s_cyc_o;
  logic [N_SLAVE-1:0]             s_stb_o;
  logic [N_SLAVE*DATA_W-1:0]      s_dat_i;
  logic [N_SLAVE*TAGSIZE-1:0]     s_tgd_i;
  logic [N_SLAVE-1:0]             s_ack_i;
  logic [N_SLAVE-1:0]             s_err_i;
  logic [N_SLAVE-1:0]             s_rty_i;

  modport ic (
    input  m_dat_i, m_adr_i, m_sel_i, m_tgd_i, m_tga_i, m_tgc_i,
    input  m_cyc_i, m_stb_i, m_we_i, m_lock_i,
    output m_dat_o, m_tgd_o, m_ack_o, m_err_o, m_rty_o, m_gnt_o,
    output s_dat_o, s_adr_o, s_sel_o, s_tgd_o, s_tga_o, s_tgc_o, s_we_o,
    output s_cyc_o, s_stb_o,
    input  s_dat_i, s_tgd_i, s_ack_i, s_err_i, s_rty_i
  );

  modport master (
    output m_dat_i, m_adr_i, m_sel_i, m_tgd_i, m_tga_i, m_tgc_i,
    output m_cyc_i, m_stb_i, m_we_i, m_lock_i,
    input  m_dat_o, m_tgd_o, m_ack_o, m_err_o, m_rty_o, m_gnt_o
  );

  modport slave (
    input  s_dat_o, s_adr_o, s_sel_o, s_tgd_o, s_tga_o, s_tgc_o, s_we_o,
    input  s_cyc_o, s_stb_o,
    output s_dat_i, s_tgd_i, s_ack_i, s_err_i, s_rty_i
  );
endinterface
`default_nettype wire

// File: rtl/wishbone_rr_interconnect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wishbone_rr_interconnect : shared-bus Wishbone, round-robin arbitration,
// bus lock and decode-miss error. Optional watchdog: WB_IC_TIMEOUT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module wishbone_rr_interconnect #(
  parameter int N_MASTER       = 2,
  parameter int N_SLAVE        = 2,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TAGSIZE        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic                      clk_i,
  input  wire logic                      rst_i,
  input  wire logic [N_SLAVE*ADDR_W-1:0] SSTART_ADDR,
  input  wire logic [N_SLAVE*ADDR_W-1:0] SEND_ADDR,
  wishbone_rr_interconnect_if.ic         bus
);
  localparam int OW   = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int SW   = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
  localparam int SELW = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DECERR = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_rr_last;
  logic [OW-1:0]   w_pick;
  logic            w_any_req;

  logic [ADDR_W-1:0]  w_adr;
  logic [DATA_W-1:0]  w_dat;
  logic [SELW-1:0]    w_sel;
  logic [TAGSIZE-1:0] w_tgd;
  logic [TAGSIZE-1:0] w_tga;
  logic [TAGSIZE-1:0] w_tgc;
  logic               w_cyc;
  logic               w_stb;
  logic               w_we;
  logic               w_lock;

  logic               w_hit;
  logic [SW-1:0]      w_hit_idx;
  logic               w_s_ack;
  logic               w_s_err;
  logic               w_s_rty;
  logic               w_timeout;

  always_comb begin
    w_adr  = bus.m_adr_i[int'(r_owner)*ADDR_W +: ADDR_W];
    w_dat  = bus.m_dat_i[int'(r_owner)*DATA_W +: DATA_W];
    w_sel  = bus.m_sel_i[int'(r_owner)*SELW +: SELW];
    w_tgd  = bus.m_tgd_i[int'(r_owner)*TAGSIZE +: TAGSIZE];
    w_tga  = bus.m_tga_i[int'(r_owner)*TAGSIZE +: TAGSIZE];
    w_tgc  = bus.m_tgc_i[int'(r_owner)*TAGSIZE +: TAGSIZE];
    w_cyc  = bus.m_cyc_i[r_owner];
    w_stb  = bus.m_stb_i[r_owner];
    w_we   = bus.m_we_i[r_owner];
    w_lock = bus.m_lock_i[r_owner];
  end

  // Scan downward so the lowest matching slave index is the one left standing.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = N_SLAVE - 1; i >= 0; i--) begin
      if ((w_adr >= SSTART_ADDR[i*ADDR_W +: ADDR_W]) &&
          (w_adr <= SEND_ADDR[i*ADDR_W +: ADDR_W])) begin
        w_hit     = 1'b1;
        w_hit_idx = SW'(i);
      end
    end
  end

  assign w_s_ack = w_hit & bus.s_ack_i[w_hit_idx];
  assign w_s_err = w_hit & bus.s_err_i[w_hit_idx];
  assign w_s_rty = w_hit & bus.s_rty_i[w_hit_idx];

  // Round-robin: the smallest offset after rr_last with cyc set wins.
  always_comb begin
    w_pick    = '0;
    w_any_req = |bus.m_cyc_i;
    for (int k = N_MASTER; k >= 1; k--) begin
      if (bus.m_cyc_i[(int'(r_rr_last) + k) % N_MASTER]) begin
        w_pick = OW'((int'(r_rr_last) + k) % N_MASTER);
      end
    end
  end

`ifdef WB_IC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;
  logic          w_stalled;

  assign w_stalled = (r_state == S_ACTIVE) && w_stb && w_hit &&
                     !(w_s_ack || w_s_err || w_s_rty);
  assign w_timeout = w_stalled && (r_to_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to_cnt <= '0;
    end else if (!w_stalled || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_owner   <= '0;
      r_rr_last <= OW'(N_MASTER - 1);
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && w_any_req) begin
        r_owner   <= w_pick;
        r_rr_last <= w_pick;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bus.m_gnt_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    bus.m_dat_o = '0;
    bus.m_tgd_o = '0;
    bus.s_dat_o = '0;
    bus.s_adr_o = '0;
    bus.s_sel_o = '0;
    bus.s_tgd_o = '0;
    bus.s_tga_o = '0;
    bus.s_tgc_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_cyc_o = '0;
    bus.s_stb_o = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        bus.m_gnt_o[r_owner] = 1'b1;
        bus.s_dat_o = w_dat;
        bus.s_sel_o = w_sel;
        bus.s_tgd_o = w_tgd;
        bus.s_tga_o = w_tga;
        bus.s_tgc_o = w_tgc;
        bus.s_we_o  = w_we;
        if (w_hit) begin
          bus.s_adr_o = w_adr - SSTART_ADDR[int'(w_hit_idx)*ADDR_W +: ADDR_W];
          bus.s_cyc_o[w_hit_idx] = w_cyc;
          bus.s_stb_o[w_hit_idx] = w_stb & ~w_timeout;
          bus.m_ack_o[r_owner]   = w_s_ack;
          bus.m_err_o[r_owner]   = w_s_err;
          bus.m_rty_o[r_owner]   = w_s_rty;
          bus.m_dat_o = bus.s_dat_i[int'(w_hit_idx)*DATA_W +: DATA_W];
          bus.m_tgd_o = bus.s_tgd_i[int'(w_hit_idx)*TAGSIZE +: TAGSIZE];
        end
        // Lock keeps ownership through cyc gaps; release only when both are low.
        if (!w_cyc && !w_lock) begin
          w_state_nxt = S_IDLE;
        end else if (w_stb && (!w_hit || w_timeout)) begin
          w_state_nxt = S_DECERR;
        end
      end
      S_DECERR: begin
        bus.m_gnt_o[r_owner] = 1'b1;
        bus.m_err_o[r_owner] = 1'b1;
        w_state_nxt = S_ACTIVE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_wishbone_rr_interconnect.sv
`default_nettype none
// Bench for wishbone_rr_interconnect: bus-ownership model plus directed tests.
module tb_wishbone_rr_interconnect;
  localparam int NM = 2, NS = 2, DW = 32, AW = 32, TS = 2, TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NS*AW-1:0] sstart, send;
  logic [NS-1:0]    ack_en;
  int checks = 0, errors = 0;

  logic [DW-1:0] slv_dat [NS];
  logic [TS-1:0] slv_tgd [NS];
  initial begin
    slv_dat[0] = 32'h0BAD_F00D; slv_dat[1] = 32'hDEAD_BEEF;
    slv_tgd[0] = 2'd1;          slv_tgd[1] = 2'd2;
  end

  wishbone_rr_interconnect_if #(.N_MASTER(NM), .N_SLAVE(NS), .DATA_W(DW),
                                .ADDR_W(AW), .TAGSIZE(TS)) bus ();

  wishbone_rr_interconnect #(.N_MASTER(NM), .N_SLAVE(NS), .DATA_W(DW), .ADDR_W(AW),
                             .TAGSIZE(TS), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .SSTART_ADDR(sstart), .SEND_ADDR(send), .bus(bus));

  assign bus.s_dat_i = {32'hDEAD_BEEF, 32'h0BAD_F00D};
  assign bus.s_tgd_i = {2'd2, 2'd1};
  assign bus.s_ack_i = bus.s_stb_o & ack_en;
  assign bus.s_err_i = '0;
  assign bus.s_rty_i = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int s = 0; s < NS; s++)
      if (a >= sstart[s*AW +: AW] && a <= send[s*AW +: AW]) return s;
    return -1;
  endfunction

  // Model: who owns the bus, whether an error response is pending, stall count.
  bit md_owned, md_errp;
  int md_own, md_last, md_stall;

  always @(posedge clk or posedge rst) begin : model
    int idx, h;
    if (rst) begin
      md_owned = 0; md_errp = 0; md_own = 0; md_last = NM - 1; md_stall = 0;
    end else if (!md_owned) begin
      if (bus.m_cyc_i != '0) begin
        for (int k = 1; k <= NM; k++) begin
          idx = (md_last + k) % NM;
          if (bus.m_cyc_i[idx]) begin md_own = idx; break; end
        end
        md_last = md_own; md_owned = 1;
      end
    end else if (md_errp) begin
      md_errp = 0;
    end else begin
      h = decode(bus.m_adr_i[md_own*AW +: AW]);
      if (!bus.m_cyc_i[md_own] && !bus.m_lock_i[md_own]) begin
        md_owned = 0; md_stall = 0;
      end else if (bus.m_stb_i[md_own] && h < 0) begin
        md_errp = 1; md_stall = 0;
      end else if (bus.m_stb_i[md_own] && !ack_en[h]) begin
`ifdef WB_IC_TIMEOUT_EN
        if (md_stall == TO) begin md_errp = 1; md_stall = 0; end
        else md_stall++;
`endif
      end else begin
        md_stall = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [NM-1:0] e_gnt, e_ack, e_err, e_rty;
    logic [NS-1:0] e_cyc, e_stb;
    logic [DW-1:0] e_mdat, e_sdat;
    logic [AW-1:0] e_sadr, a;
    logic [3:0]    e_sel;
    logic [TS-1:0] e_mtgd, e_tgd, e_tga, e_tgc;
    logic          e_we, stb, fire;
    int            h;
    e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0; e_cyc = '0; e_stb = '0;
    e_mdat = '0; e_sdat = '0; e_sadr = '0; e_sel = '0; e_mtgd = '0;
    e_tgd = '0; e_tga = '0; e_tgc = '0; e_we = 1'b0;
    if (!rst && md_owned) begin
      e_gnt[md_own] = 1'b1;
      if (md_errp) begin
        e_err[md_own] = 1'b1;
      end else begin
        a      = bus.m_adr_i[md_own*AW +: AW];
        stb    = bus.m_stb_i[md_own];
        e_sdat = bus.m_dat_i[md_own*DW +: DW];
        e_sel  = bus.m_sel_i[md_own*4 +: 4];
        e_tgd  = bus.m_tgd_i[md_own*TS +: TS];
        e_tga  = bus.m_tga_i[md_own*TS +: TS];
        e_tgc  = bus.m_tgc_i[md_own*TS +: TS];
        e_we   = bus.m_we_i[md_own];
        h      = decode(a);
        if (h >= 0) begin
          fire = 1'b0;
`ifdef WB_IC_TIMEOUT_EN
          fire = stb && !ack_en[h] && (md_stall == TO);
`endif
          e_sadr        = a - sstart[h*AW +: AW];
          e_cyc[h]      = bus.m_cyc_i[md_own];
          e_stb[h]      = stb && !fire;
          e_ack[md_own] = e_stb[h] && ack_en[h];
          e_mdat        = slv_dat[h];
          e_mtgd        = slv_tgd[h];
        end
      end
    end
    chk("master_side", {bus.m_gnt_o, bus.m_ack_o, bus.m_err_o, bus.m_rty_o, bus.m_dat_o, bus.m_tgd_o},
        {e_gnt, e_ack, e_err, e_rty, e_mdat, e_mtgd});
    chk("slave_side", {bus.s_cyc_o, bus.s_stb_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o,
                       bus.s_tgd_o, bus.s_tga_o, bus.s_tgc_o, bus.s_we_o},
        {e_cyc, e_stb, e_sadr, e_sdat, e_sel, e_tgd, e_tga, e_tgc, e_we});
  end

  task automatic set_m(input int m, input logic [AW-1:0] a, input logic c, input logic l);
    bus.m_adr_i[m*AW +: AW] = a;
    bus.m_cyc_i[m]  = c;
    bus.m_stb_i[m]  = c;
    bus.m_lock_i[m] = l;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [NM-1:0] acked, prev;
    int gr [4];
    int ngr, errcnt;
    sstart = {32'h0000_1000, 32'h0000_0000};
    send   = {32'h0000_1FFF, 32'h0000_0FFF};
    ack_en = 2'b11;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_lock_i = '0; bus.m_adr_i = '0;
    bus.m_we_i  = 2'b10;
    bus.m_dat_i = {32'hCAFE_0001, 32'hCAFE_0000};
    bus.m_sel_i = {4'h3, 4'hF};
    bus.m_tgd_i = {2'd2, 2'd1};
    bus.m_tga_i = {2'd3, 2'd2};
    bus.m_tgc_i = {2'd1, 2'd3};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_idle_gnt", bus.m_gnt_o, 2'b00);
    chk("reset_idle_stb", bus.s_stb_o, 2'b00);

    // Single read from slave 1
    step(); set_m(0, 32'h0000_1004, 1'b1, 1'b0);
    @(negedge clk);
    chk("single_gnt_wait", bus.m_gnt_o, 2'b00);
    @(negedge clk);
    chk("single_gnt", bus.m_gnt_o, 2'b01);
    chk("single_stb", bus.s_stb_o, 2'b10);
    chk("single_sadr", bus.s_adr_o, 32'h4);
    chk("single_ack", bus.m_ack_o, 2'b01);
    chk("single_dat", bus.m_dat_o, 32'hDEAD_BEEF);
    step(); set_m(0, 32'h0000_1004, 1'b0, 1'b0);

    // Round robin: master 0 was last owner, so master 1 goes first
    step();
    set_m(0, 32'h0000_0010, 1'b1, 1'b0);
    set_m(1, 32'h0000_1020, 1'b1, 1'b0);
    ngr = 0; prev = '0;
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      @(negedge clk);
      acked = bus.m_ack_o;
      if (bus.m_gnt_o != '0 && bus.m_gnt_o != prev) begin
        gr[ngr] = (bus.m_gnt_o == 2'b10) ? 1 : 0;
        ngr++;
      end
      prev = bus.m_gnt_o;
      step();
      bus.m_cyc_i = ~acked;
      bus.m_stb_i = ~acked;
    end
    bus.m_cyc_i = '0; bus.m_stb_i = '0;
    chk("rr_grant_count", ngr, 4);
    chk("rr_grant_0", gr[0], 1);
    chk("rr_grant_1", gr[1], 0);
    chk("rr_grant_2", gr[2], 1);
    chk("rr_grant_3", gr[3], 0);
    repeat (2) step();

    // Lock: master 1 holds the bus across a cyc gap while master 0 waits
    set_m(1, 32'h0000_0040, 1'b1, 1'b1);
    step(); set_m(0, 32'h0000_0080, 1'b1, 1'b0);
    @(negedge clk); chk("lock_gnt_a", bus.m_gnt_o, 2'b10);
    step(); bus.m_cyc_i[1] = 1'b0; bus.m_stb_i[1] = 1'b0;
    @(negedge clk); chk("lock_gnt_gap1", bus.m_gnt_o, 2'b10);
    step();
    @(negedge clk); chk("lock_gnt_gap2", bus.m_gnt_o, 2'b10);
    step(); bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1;
    @(negedge clk); chk("lock_gnt_b", bus.m_gnt_o, 2'b10);
    chk("lock_ack_b", bus.m_ack_o, 2'b10);
    step(); set_m(1, 32'h0000_0040, 1'b0, 1'b0);
    @(negedge clk); chk("lock_release_cycle", bus.m_gnt_o, 2'b10);
    @(negedge clk); chk("lock_idle_gap", bus.m_gnt_o, 2'b00);
    @(negedge clk); chk("lock_m0_granted", bus.m_gnt_o, 2'b01);

    // Decode miss by master 0
    step(); ack_en = 2'b00; bus.m_adr_i[0 +: AW] = 32'hFFFF_0000;
    @(negedge clk);
    chk("miss_no_stb", bus.s_stb_o, 2'b00);
    chk("miss_err_not_yet", bus.m_err_o, 2'b00);
    step(); bus.m_stb_i[0] = 1'b0; bus.m_adr_i[0 +: AW] = 32'h0000_0080;
    @(negedge clk);
    chk("miss_err_pulse", bus.m_err_o, 2'b01);
    chk("miss_no_ack", bus.m_ack_o, 2'b00);
    @(negedge clk);
    chk("miss_err_once", bus.m_err_o, 2'b00);

    // Stalled slave
    step(); bus.m_stb_i[0] = 1'b1;
    errcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.m_err_o[0]) errcnt++;
    end
`ifdef WB_IC_TIMEOUT_EN
    chk("timeout_err_seen", errcnt > 0, 1'b1);
`else
    chk("stall_no_err", errcnt, 0);
    chk("stall_still_stb", bus.s_stb_o, 2'b01);
`endif

    // Asynchronous reset in the middle of the stalled transfer
    #2 rst = 1'b1;
    #1;
    chk("rst_async_all", {bus.m_gnt_o, bus.m_ack_o, bus.m_err_o, bus.m_rty_o, bus.m_dat_o, bus.m_tgd_o,
                          bus.s_cyc_o, bus.s_stb_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o,
                          bus.s_tgd_o, bus.s_tga_o, bus.s_tgc_o, bus.s_we_o}, '0);
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_lock_i = '0;
    step(); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {bus.m_gnt_o, bus.m_ack_o, bus.m_err_o, bus.s_cyc_o, bus.s_stb_o}, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
